// File: rtl/data_memory_responder.sv
// data_memory_responder: memory-side responder for the execute-stage
// load/store port. A synchronous-read RAM of DATA_W-bit words serves byte,
// dword and qword loads; loads that straddle a word boundary take a second
// read beat and stall the requester for one cycle.
//
// Handshake: the requester presents a request every cycle. A request is
// consumed on the rising edge whenever stall is low. While stall is high the
// requester must hold every request input unchanged. Loads return ld_valid
// for exactly one cycle, in request order, with no back-pressure from the
// receiver.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef REG_W
`define REG_W 64
`endif

module data_memory_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_W     = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [`ADDR_W-1:0]     mem_addr,
  input  logic [2:0]             ld_offset,
  input  logic [1:0]             ld_size,
  input  logic [`REG_ADDR_W-1:0] ld_tag,
  input  logic [DATA_W-1:0]      st_data,
  input  logic [DATA_W/8-1:0]    we,
  output logic                   stall,
  output logic                   ld_valid,
  output logic [`REG_W-1:0]      ld_data,
  output logic [`REG_ADDR_W-1:0] ld_tag_o,
  output logic                   state_dbg
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SPLIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] hold_q;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2-1:0] req_addr;

  // Latched split request (valid while in SPLIT)
  logic [DEPTH_LOG2-1:0]   lat_addr;
  logic [2:0]              lat_off;
  logic [1:0]              lat_size;
  logic [`REG_ADDR_W-1:0]  lat_tag;

  // Read-data stage: describes the word sitting in rd_q this cycle
  logic                    p1_valid, p1_valid_nxt;
  logic                    p1_split, p1_split_nxt;
  logic [2:0]              p1_off, p1_off_nxt;
  logic [1:0]              p1_size, p1_size_nxt;
  logic [`REG_ADDR_W-1:0]  p1_tag, p1_tag_nxt;

  logic is_load, is_store, split_req;
  logic [2*DATA_W-1:0] combo;
  logic [2*DATA_W-1:0] shifted;
  logic [`REG_W-1:0]   extracted;

  assign req_addr  = mem_addr[DEPTH_LOG2-1:0];
  assign is_load   = (ld_size != 2'b00);
  assign is_store  = (we != '0);
  assign split_req = ((ld_size == 2'b10) && (ld_offset >= 3'd5)) ||
                     ((ld_size == 2'b11) && (ld_offset != 3'd0));
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, stall, read address and read-stage bookkeeping
  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    rd_addr      = req_addr;
    p1_valid_nxt = 1'b0;
    p1_split_nxt = 1'b0;
    p1_off_nxt   = ld_offset;
    p1_size_nxt  = ld_size;
    p1_tag_nxt   = ld_tag;
    case (state)
      S_IDLE: begin
        if (is_load && split_req) begin
          // First beat reads word A; the result is assembled after beat two
          stall     = rstn;
          state_nxt = S_SPLIT;
        end else if (is_load) begin
          p1_valid_nxt = 1'b1;
        end
      end
      S_SPLIT: begin
        // Second beat reads the following word; wraps at the top of the RAM
        rd_addr      = lat_addr + 1'b1;
        p1_valid_nxt = 1'b1;
        p1_split_nxt = 1'b1;
        p1_off_nxt   = lat_off;
        p1_size_nxt  = lat_size;
        p1_tag_nxt   = lat_tag;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // RAM: byte-enabled write and synchronous read; hold captures word A of a split
  always_ff @(posedge clk) begin
    if (state == S_IDLE && is_store) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) mem[req_addr][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
    rd_q <= mem[rd_addr];
    if (state == S_SPLIT) hold_q <= rd_q;
  end

  // Split-request latch and read-stage registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_addr <= '0;
      lat_off  <= '0;
      lat_size <= '0;
      lat_tag  <= '0;
      p1_valid <= 1'b0;
      p1_split <= 1'b0;
      p1_off   <= '0;
      p1_size  <= '0;
      p1_tag   <= '0;
    end else begin
      if (state == S_IDLE && is_load && split_req) begin
        lat_addr <= req_addr;
        lat_off  <= ld_offset;
        lat_size <= ld_size;
        lat_tag  <= ld_tag;
      end
      p1_valid <= p1_valid_nxt;
      p1_split <= p1_split_nxt;
      p1_off   <= p1_off_nxt;
      p1_size  <= p1_size_nxt;
      p1_tag   <= p1_tag_nxt;
    end
  end

  // Byte extraction: shift the (high,low) word pair down by the offset, then mask by size
  always_comb begin
    combo     = p1_split ? {rd_q, hold_q} : {{DATA_W{1'b0}}, rd_q};
    shifted   = combo >> {p1_off, 3'b000};
    extracted = shifted[`REG_W-1:0];
    case (p1_size)
      2'b01:   extracted = {{(`REG_W-8){1'b0}},  shifted[7:0]};
      2'b10:   extracted = {{(`REG_W-32){1'b0}}, shifted[31:0]};
      default: extracted = shifted[`REG_W-1:0];
    endcase
  end

  // Writeback register: one-cycle ld_valid pulse with aligned data and tag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_valid <= 1'b0;
      ld_data  <= '0;
      ld_tag_o <= '0;
    end else begin
      ld_valid <= p1_valid;
      if (p1_valid) begin
        ld_data  <= extracted;
        ld_tag_o <= p1_tag;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: stores, aligned/split loads,
// read-after-write, address wrap and reset during a split beat.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef REG_W
`define REG_W 64
`endif

module tb_data_memory_responder;

  localparam int EW = 32 + 5 + 64;

  logic                   clk;
  logic                   rstn;
  logic [`ADDR_W-1:0]     mem_addr;
  logic [2:0]             ld_offset;
  logic [1:0]             ld_size;
  logic [`REG_ADDR_W-1:0] ld_tag;
  logic [63:0]            st_data;
  logic [7:0]             we;
  logic                   stall;
  logic                   ld_valid;
  logic [`REG_W-1:0]      ld_data;
  logic [`REG_ADDR_W-1:0] ld_tag_o;
  logic                   state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];

  data_memory_responder #(.DEPTH_LOG2(12), .DATA_W(64)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_addr  (mem_addr),
    .ld_offset (ld_offset),
    .ld_size   (ld_size),
    .ld_tag    (ld_tag),
    .st_data   (st_data),
    .we        (we),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_tag_o  (ld_tag_o),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every returned load must match the oldest expectation, on its cycle
  always @(negedge clk) begin
    if (rstn && ld_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_ld_valid", 64'd1, 64'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("ld_data",  ld_data,  e[63:0]);
        check("ld_tag_o", {59'd0, ld_tag_o}, {59'd0, e[68:64]});
        check("ld_cycle", 64'(cyc), {32'd0, e[100:69]});
      end
    end
  end

  task automatic set_inputs(input logic [31:0] a, input logic [2:0] off, input logic [1:0] sz,
                            input logic [4:0] tg, input logic [63:0] sd, input logic [7:0] w);
    mem_addr  = a;
    ld_offset = off;
    ld_size   = sz;
    ld_tag    = tg;
    st_data   = sd;
    we        = w;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_inputs(32'd0, 3'd0, 2'b00, 5'd0, 64'd0, 8'h00);
    @(negedge clk);
    check("nop_stall", {63'd0, stall}, 64'd0);
    next_cycle();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [63:0] sd, input logic [7:0] w);
    set_inputs(a, 3'd0, 2'b00, 5'd0, sd, w);
    @(negedge clk);
    check("store_stall", {63'd0, stall}, 64'd0);
    next_cycle();
  endtask

  // Load: stall expected only in the first beat of a split; data at T+2 or T+3
  task automatic do_load(input logic [31:0] a, input logic [2:0] off, input logic [1:0] sz,
                         input logic [4:0] tg, input logic split, input logic [63:0] exp_data);
    set_inputs(a, off, sz, tg, 64'd0, 8'h00);
    exp_q.push_back({32'(cyc + (split ? 3 : 2)), tg, exp_data});
    @(negedge clk);
    check("load_stall", {63'd0, stall}, {63'd0, split});
    next_cycle();
    if (split) begin
      @(negedge clk);
      check("split_beat2_stall", {63'd0, stall}, 64'd0);
      next_cycle();
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_inputs(32'd0, 3'd0, 2'b00, 5'd0, 64'd0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ld_valid", {63'd0, ld_valid}, 64'd0);
    check("rst_ld_data",  ld_data, 64'd0);
    check("rst_ld_tag_o", {59'd0, ld_tag_o}, 64'd0);
    check("rst_stall",    {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Preload
    do_store(32'h10, 64'h8877665544332211, 8'hFF);
    do_store(32'h11, 64'h00FFEEDDCCBBAA99, 8'hFF);

    // Aligned qword and byte loads, back-to-back bytes
    do_load(32'h10, 3'd0, 2'b11, 5'd5, 1'b0, 64'h8877665544332211);
    do_load(32'h10, 3'd3, 2'b01, 5'd1, 1'b0, 64'h44);
    do_load(32'h10, 3'd0, 2'b01, 5'd2, 1'b0, 64'h11);
    do_load(32'h10, 3'd1, 2'b01, 5'd3, 1'b0, 64'h22);
    do_load(32'h10, 3'd2, 2'b01, 5'd4, 1'b0, 64'h33);
    // Byte at offset 7 never splits; upper address bits ignored (0x1010 -> 0x10)
    do_load(32'h1010, 3'd7, 2'b01, 5'd11, 1'b0, 64'h88);
    // Aligned dword at the largest non-splitting offset
    do_load(32'h11, 3'd4, 2'b10, 5'd12, 1'b0, 64'h00FFEEDD);

    // Split loads issued back-to-back after an aligned one
    do_load(32'h10, 3'd6, 2'b10, 5'd6, 1'b1, 64'h00000000AA998877);
    do_load(32'h10, 3'd7, 2'b11, 5'd7, 1'b1, 64'hFFEEDDCCBBAA9988);
    do_load(32'h10, 3'd5, 2'b10, 5'd13, 1'b1, 64'h0000000099887766);

    // Partial store then immediate read-after-write
    do_store(32'h10, 64'h00000000DEAD0000, 8'h0C);
    do_load(32'h10, 3'd0, 2'b10, 5'd8, 1'b0, 64'h00000000DEAD2211);
    do_load(32'h10, 3'd0, 2'b11, 5'd14, 1'b0, 64'h88776655DEAD2211);

    // Address wrap: last word then word 0
    do_store(32'hFFF, 64'h1111111111111111, 8'hFF);
    do_store(32'h000, 64'h2222222222222222, 8'hFF);
    do_load(32'hFFF, 3'd4, 2'b11, 5'd9, 1'b1, 64'h2222222211111111);

    repeat (4) nop();
    check("pre_reset_drain", 64'(exp_q.size()), 64'd0);

    // Reset pulsed during the SPLIT beat of a split dword load
    set_inputs(32'h11, 3'd6, 2'b10, 5'd10, 64'd0, 8'h00);
    @(negedge clk);
    check("rst_split_beat1_stall", {63'd0, stall}, 64'd1);
    next_cycle();
    rstn = 1'b0;
    #1;
    check("rst_split_stall_forced", {63'd0, stall}, 64'd0);
    @(negedge clk);
    check("rst_split_ld_valid", {63'd0, ld_valid}, 64'd0);
    check("rst_split_stall", {63'd0, stall}, 64'd0);
    next_cycle();
    @(negedge clk);
    check("rst_split_ld_data", ld_data, 64'd0);
    check("rst_split_valid2", {63'd0, ld_valid}, 64'd0);
    set_inputs(32'd0, 3'd0, 2'b00, 5'd0, 64'd0, 8'h00);
    next_cycle();
    rstn = 1'b1;
    repeat (3) nop();
    do_load(32'h11, 3'd0, 2'b01, 5'd3, 1'b0, 64'h99);
    do_load(32'h11, 3'd0, 2'b11, 5'd15, 1'b0, 64'h00FFEEDDCCBBAA99);

    repeat (6) nop();
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
